// File: rtl/riscv_pkg.sv
// Definitions shared by the fetch front end: the NOP encoding, the default
// reset PC and the state of a fetch-queue entry.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ENTRY_EMPTY   = 2'd0,
    ENTRY_PENDING = 2'd1,
    ENTRY_READY   = 2'd2
  } entry_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of in-flight fetches. An entry is allocated PENDING when its
// request is accepted, becomes READY when its word returns, and is popped from
// the head by decode. Responses return in order, so the entries from the head
// are always some READY ones followed by the PENDING ones. Because of that, a
// fill pointer is enough to find the oldest PENDING entry.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [31:0]      alloc_pc,
  input  logic             fill,
  input  logic [31:0]      fill_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] alloc_cnt,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             head_ready,
  output logic [31:0]      head_pc,
  output logic [31:0]      head_data
);

  entry_state_e     state_q [DEPTH];
  entry_state_e     state_d [DEPTH];
  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      pc_d    [DEPTH];
  logic [31:0]      data_q  [DEPTH];
  logic [31:0]      data_d  [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CNT_W-1:0] count_q, count_d, ready_q, ready_d;

  assign alloc_cnt   = count_q;
  assign pending_cnt = count_q - ready_q;
  assign head_ready  = (state_q[head_q] == ENTRY_READY);
  assign head_pc     = pc_q[head_q];
  assign head_data   = data_q[head_q];

  // Next-state of the buffer: pop first, then fill, then allocate, so that an
  // allocation into the slot freed by a same-cycle pop is not lost.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    count_d = count_q;
    ready_d = ready_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) state_d[i] = ENTRY_EMPTY;
      head_d  = '0;
      tail_d  = '0;
      fill_d  = '0;
      count_d = '0;
      ready_d = '0;
    end else begin
      if (pop && head_ready) begin
        state_d[head_q] = ENTRY_EMPTY;
        head_d  = head_q + PTR_W'(1);
        count_d = count_d - CNT_W'(1);
        ready_d = ready_d - CNT_W'(1);
      end
      if (fill && (pending_cnt != '0)) begin
        state_d[fill_q] = ENTRY_READY;
        data_d[fill_q]  = fill_data;
        fill_d  = fill_q + PTR_W'(1);
        ready_d = ready_d + CNT_W'(1);
      end
      if (alloc) begin
        state_d[tail_q] = ENTRY_PENDING;
        pc_d[tail_q]    = alloc_pc;
        tail_d  = tail_q + PTR_W'(1);
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  // Buffer registers with synchronous reset to an empty queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ENTRY_EMPTY;
        pc_q[i]    <= '0;
        data_q[i]  <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end. It owns PCF and issues in-order fetches. Fetches
// that a redirect has made stale are counted in drop_cnt and their responses are
// discarded. Returned words are fed into the IF/ID register, which honours
// stall and flush.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int               CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [31:0]      pcf_q, pcf_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      instr_q, instr_d, pcd_q, pcd_d, pcplus4_q, pcplus4_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] alloc_cnt, pending_cnt;
  logic             head_ready;
  logic [31:0]      head_pc, head_data;
  logic             pop, issue, fire, fill;

  assign pop   = !PCSrcE && !FlushD && !StallD && head_ready;
  assign issue = !reset && !PCSrcE && ((alloc_cnt < DEPTH_CNT) || pop);
  assign fire  = issue && imem_req_ready;
  assign fill  = imem_rsp_valid && !PCSrcE && (drop_cnt_q == '0);

  assign imem_req_valid = issue;
  assign imem_req_addr  = pcf_q;
  assign InstrD         = instr_q;
  assign PCD            = pcd_q;
  assign PCPlus4D       = pcplus4_q;
  assign ValidD         = valid_q;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset       (reset),
    .alloc       (fire),
    .alloc_pc    (pcf_q),
    .fill        (fill),
    .fill_data   (imem_rsp_data),
    .pop         (pop),
    .flush       (PCSrcE),
    .alloc_cnt   (alloc_cnt),
    .pending_cnt (pending_cnt),
    .head_ready  (head_ready),
    .head_pc     (head_pc),
    .head_data   (head_data)
  );

  // PCF and the stale-response count. A response that arrives in the redirect
  // cycle uses up one of the outstanding fetches counted in that cycle.
  always_comb begin
    pcf_d      = pcf_q;
    drop_cnt_d = drop_cnt_q;
    if (PCSrcE) begin
      pcf_d      = PCTargetE;
      drop_cnt_d = drop_cnt_q + pending_cnt - CNT_W'(imem_rsp_valid);
    end else begin
      if (fire) pcf_d = pcf_q + 32'd4;
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  // IF/ID register: a flush or redirect beats a stall, and a stall beats a pop.
  always_comb begin
    instr_d   = instr_q;
    pcd_d     = pcd_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    if (PCSrcE || FlushD) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!StallD) begin
      if (head_ready) begin
        valid_d   = 1'b1;
        instr_d   = head_data;
        pcd_d     = head_pc;
        pcplus4_d = head_pc + 32'd4;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q      <= RESET_PC;
      drop_cnt_q <= '0;
      instr_q    <= NOP_INSTR;
      pcd_q      <= '0;
      pcplus4_q  <= '0;
      valid_q    <= 1'b0;
    end else begin
      pcf_q      <= pcf_d;
      drop_cnt_q <= drop_cnt_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcplus4_q  <= pcplus4_d;
      valid_q    <= valid_d;
    end
  end

  // Memory must never return a word that no fetch is waiting for.
  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> ((drop_cnt_q != '0) || (pending_cnt != '0)));

endmodule
